// File: rtl/sipo_y_ctrl_pkg.sv
// sipo_y_ctrl_pkg: shared defaults, FSM state encoding and width helper for the y-vector SIPO sequencer.
// The watchdog default only exists when SIPO_Y_CTRL_TIMEOUT_EN is defined.
package sipo_y_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int LOAD_LEN_DEF   = 32;
    localparam int SHIFT_LEN_DEF  = 16;
`ifdef SIPO_Y_CTRL_TIMEOUT_EN
    localparam int TIMEOUT_DEF    = 256;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_PE,
        S_SHIFT,
        S_DONE
    } state_e;

    // Counter width that still holds n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sipo_y_ctrl_counter.sv
// ctrl_counter: ce-gated up-counter with synchronous clear, saturating at MAX with a terminal-count flag.
module ctrl_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = cnt_q == W'(MAX);
    assign cnt_o = cnt_q;

    always_comb cnt_d = clr_i ? '0 : (inc_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (ce_i)
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sipo_y_ctrl.sv
// sipo_y_ctrl: load/shift sequencer for the y-vector SIPO feeding the PE array.
// Optional WAIT_PE watchdog enabled by defining SIPO_Y_CTRL_TIMEOUT_EN.
module sipo_y_ctrl
    import sipo_y_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LOAD_LEN   = LOAD_LEN_DEF,
    parameter int SHIFT_LEN  = SHIFT_LEN_DEF
`ifdef SIPO_Y_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = TIMEOUT_DEF
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce_i,
    input  logic                          in_v_i,
    input  logic [2*DATA_WIDTH-1:0]       in_data_i,
    output logic                          in_rdy_o,
    input  logic                          pe_rdy_i,
    output logic                          s_in_v_o,
    output logic [2*DATA_WIDTH-1:0]       s_in_o,
    output logic                          shift_v_o,
    output logic                          frame_done_o,
    output logic                          busy_o,
    output logic [$clog2(LOAD_LEN+1)-1:0] load_cnt_o,
    output logic                          err_timeout_o
);

    localparam int LW = $clog2(LOAD_LEN + 1);
    localparam int SW = cnt_w(SHIFT_LEN);

    state_e                  state_q;
    logic                    s_in_v_q, shift_v_q, frame_done_q;
    logic [2*DATA_WIDTH-1:0] s_in_q;
    logic                    accept, load_full, load_last, shift_last, tmo;
    logic [SW-1:0]           shift_cnt_unused;

    assign in_rdy_o     = ce_i && (state_q == S_IDLE || state_q == S_LOAD) && !load_full;
    assign accept       = in_v_i && in_rdy_o;
    assign load_last    = load_cnt_o == LW'(LOAD_LEN - 1);
    assign busy_o       = state_q != S_IDLE;
    assign s_in_v_o     = s_in_v_q;
    assign s_in_o       = s_in_q;
    assign shift_v_o    = shift_v_q;
    assign frame_done_o = frame_done_q;

    ctrl_counter #(.W(LW), .MAX(LOAD_LEN)) u_load_cnt (
        .clk   (clk),
        .rst   (rst),
        .ce_i  (ce_i),
        .clr_i (state_q == S_DONE || tmo),
        .inc_i (accept),
        .cnt_o (load_cnt_o),
        .tc_o  (load_full)
    );

    // Cleared outside SHIFT so every burst starts from zero.
    ctrl_counter #(.W(SW), .MAX(SHIFT_LEN - 1)) u_shift_cnt (
        .clk   (clk),
        .rst   (rst),
        .ce_i  (ce_i),
        .clr_i (state_q != S_SHIFT),
        .inc_i (state_q == S_SHIFT),
        .cnt_o (shift_cnt_unused),
        .tc_o  (shift_last)
    );

`ifdef SIPO_Y_CTRL_TIMEOUT_EN
    localparam int TW = cnt_w(TIMEOUT);

    logic          wd_tc, err_q;
    logic [TW-1:0] wd_cnt_unused;

    ctrl_counter #(.W(TW), .MAX(TIMEOUT - 1)) u_wd_cnt (
        .clk   (clk),
        .rst   (rst),
        .ce_i  (ce_i),
        .clr_i (state_q != S_WAIT_PE || pe_rdy_i),
        .inc_i (state_q == S_WAIT_PE && !pe_rdy_i),
        .cnt_o (wd_cnt_unused),
        .tc_o  (wd_tc)
    );

    assign tmo           = state_q == S_WAIT_PE && !pe_rdy_i && wd_tc;
    assign err_timeout_o = err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (ce_i && tmo)
            err_q <= 1'b1;
    end
`else
    assign tmo           = 1'b0;
    assign err_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            s_in_v_q     <= 1'b0;
            s_in_q       <= '0;
            shift_v_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (ce_i) begin
            s_in_v_q     <= accept;
            frame_done_q <= 1'b0;
            if (accept)
                s_in_q <= in_data_i;
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (accept)
                        state_q <= load_last ? S_WAIT_PE : S_LOAD;
                end
                S_WAIT_PE: begin
                    if (pe_rdy_i) begin
                        shift_v_q <= 1'b1;
                        state_q   <= S_SHIFT;
                    end else if (tmo) begin
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (shift_last) begin
                        shift_v_q    <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_y_ctrl.sv
// tb_sipo_y_ctrl: directed scenarios plus random traffic against a frame-level reference model.
// The watchdog scenario runs only when SIPO_Y_CTRL_TIMEOUT_EN is defined.
module tb_sipo_y_ctrl;

    localparam int DW = 16;
    localparam int LL = 32;
    localparam int SL = 16;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          rst, ce, in_v, pe_rdy;
    logic [2*DW-1:0] in_data;
    logic          in_rdy, s_in_v, shift_v, frame_done, busy, err_timeout;
    logic [2*DW-1:0] s_in;
    logic [5:0]    load_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: samples held, phase flags and burst cycles left.
    int          m_cnt, m_left, m_wd;
    bit          m_wait, m_done, m_sv, m_fd, m_siv, m_err;
    logic [31:0] m_sin;
    logic [31:0] nxt;

    always #5 clk = ~clk;

    sipo_y_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ce_i          (ce),
        .in_v_i        (in_v),
        .in_data_i     (in_data),
        .in_rdy_o      (in_rdy),
        .pe_rdy_i      (pe_rdy),
        .s_in_v_o      (s_in_v),
        .s_in_o        (s_in),
        .shift_v_o     (shift_v),
        .frame_done_o  (frame_done),
        .busy_o        (busy),
        .load_cnt_o    (load_cnt),
        .err_timeout_o (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_rdy(input bit c);
        return c && !m_wait && m_left == 0 && !m_done && m_cnt < LL;
    endfunction

    task automatic step(input bit c, input bit v, input bit p, input bit r, input logic [31:0] d);
        bit acc;
        ce = c; in_v = v; pe_rdy = p; rst = r; in_data = d;
        #1;
        if (!r)
            chk("in_rdy", {31'b0, in_rdy}, {31'b0, m_rdy(c)});
        acc = v && m_rdy(c) && !r;
        if (acc)
            nxt++;
        if (r) begin
            m_cnt = 0; m_left = 0; m_wd = 0; m_wait = 0; m_done = 0;
            m_sv = 0; m_fd = 0; m_siv = 0; m_err = 0; m_sin = 0;
        end else if (c) begin
            m_siv = acc;
            m_fd  = 0;
            if (acc)
                m_sin = d;
            if (m_done) begin
                m_done = 0;
                m_cnt  = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_sv = 0; m_fd = 1; m_done = 1;
                end
            end else if (m_wait) begin
                if (p) begin
                    m_wait = 0; m_left = SL; m_sv = 1;
                end
`ifdef SIPO_Y_CTRL_TIMEOUT_EN
                else if (++m_wd == TO) begin
                    m_wait = 0; m_cnt = 0; m_err = 1;
                end
`endif
            end else if (acc) begin
                m_cnt++;
                if (m_cnt == LL) begin
                    m_wait = 1; m_wd = 0;
                end
            end
        end
        @(negedge clk);
        chk("s_in_v", {31'b0, s_in_v}, {31'b0, m_siv});
        chk("s_in", s_in, m_sin);
        chk("shift_v", {31'b0, shift_v}, {31'b0, m_sv});
        chk("frame_done", {31'b0, frame_done}, {31'b0, m_fd});
        chk("busy", {31'b0, busy}, {31'b0, (m_cnt > 0 || m_wait || m_left > 0 || m_done)});
        chk("load_cnt", {26'b0, load_cnt}, m_cnt);
        chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_err});
    endtask

    initial begin
        ce = 0; in_v = 0; pe_rdy = 0; rst = 1; in_data = '0; nxt = 1;
        @(negedge clk);
        repeat (5) step(1, 0, 0, 1, 0);
        for (int i = 0; i < 60; i++) step(1, nxt <= 32, 1, 0, nxt);
        for (int i = 0; i < 90; i++) step(1, !i[0] && nxt <= 64, 1, 0, nxt);
        for (int i = 0; i < 32; i++) step(1, 1, 0, 0, nxt);
        repeat (40) step(1, 0, 0, 0, 0);
        repeat (25) step(1, 0, 1, 0, 0);
        for (int i = 0; i < 32; i++) step(1, 1, 1, 0, nxt);
        for (int i = 0; i < 40 && m_left != SL - 7; i++) step(1, 0, 1, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0);
        repeat (25) step(1, 0, 1, 0, 0);
        for (int i = 0; i < 40 && m_cnt < 10; i++) step(1, 1, 0, 0, nxt);
        step(1, 1, 0, 1, nxt);
        repeat (3) step(1, 0, 0, 0, 0);
`ifdef SIPO_Y_CTRL_TIMEOUT_EN
        for (int i = 0; i < 32; i++) step(1, 1, 0, 0, nxt);
        repeat (TO + 10) step(1, 0, 0, 0, 0);
`endif
        repeat (4000)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 999) == 0, $urandom);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
